// File: rtl/telemetry_pkg.sv
// rtl/telemetry_pkg.sv - shared constants, FSM states and snapshot byte selection for telemetry
package telemetry_pkg;

  localparam logic [7:0] HDR0      = 8'hAA;
  localparam logic [7:0] HDR1      = 8'h55;
  localparam int         PKT_BYTES = 8;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} tlm_state_t;

  typedef struct packed {
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
  } snap_t;

  function automatic logic [7:0] byte_sel(input snap_t s, input logic [2:0] idx);
    case (idx)
      3'd0:    byte_sel = HDR0;
      3'd1:    byte_sel = HDR1;
      3'd2:    byte_sel = {4'h0, s.batt[11:8]};
      3'd3:    byte_sel = s.batt[7:0];
      3'd4:    byte_sel = {4'h0, s.curr[11:8]};
      3'd5:    byte_sel = s.curr[7:0];
      3'd6:    byte_sel = {4'h0, s.torque[11:8]};
      default: byte_sel = s.torque[7:0];
    endcase
  endfunction

endpackage

// File: rtl/telemetry_uart_tx.sv
// rtl/telemetry_uart_tx.sv - 8N1 UART transmitter, BAUD_DIV clocks per bit, tx_done one cycle after stop
module UART_tx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV + 1);

  logic          active_q, active_d;
  logic [8:0]    shift_q, shift_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;

  // shift_q holds the data bits followed by the stop bit; the start bit goes straight to tx_q
  always_comb begin
    active_d   = active_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    if (trmt && !active_q) begin
      active_d   = 1'b1;
      shift_d    = {1'b1, tx_data};
      bit_cnt_d  = 4'd0;
      baud_cnt_d = '0;
      tx_d       = 1'b0;
    end else if (active_q) begin
      if (baud_cnt_q == BW'(BAUD_DIV - 1)) begin
        baud_cnt_d = '0;
        if (bit_cnt_q == 4'd9) begin
          active_d  = 1'b0;
          tx_d      = 1'b1;
          tx_done_d = 1'b1;
        end else begin
          tx_d      = shift_q[0];
          shift_d   = {1'b1, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        baud_cnt_d = baud_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      shift_q    <= '1;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      active_q   <= active_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/telemetry.sv
// rtl/telemetry.sv - periodic/requested 8-byte telemetry packet scheduler driving a UART TX pin
module telemetry
  import telemetry_pkg::*;
#(
  parameter int FAST_SIM = 1,
  parameter int BAUD_DIV = 2604,
  parameter int PER_W    = (FAST_SIM != 0) ? 18 : 22
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic        send_req,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done
);

  tlm_state_t       state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [PER_W-1:0] timer_q, timer_d;
  snap_t            snap_q, snap_d;

  logic       tick, trig, trmt, tx_done;
  logic [7:0] tx_data;

  assign busy = (state_q != IDLE);
  assign tick = &timer_q;
  assign trig = (tick | send_req) & ~busy;

  // only an accepted request restarts the period; ticks simply wrap
  assign timer_d = (send_req && !busy) ? '0 : timer_q + PER_W'(1);

  assign tx_data = byte_sel(snap_q, idx_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    trmt     = 1'b0;
    pkt_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d       = LOAD;
          idx_d         = 3'd0;
          snap_d.batt   = batt;
          snap_d.curr   = curr;
          snap_d.torque = torque;
        end
      end
      LOAD: begin
        trmt    = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (idx_q == 3'(PKT_BYTES - 1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end
        end
      end
      default: begin
        pkt_done = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      timer_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      snap_q  <= snap_d;
    end
  end

  UART_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

endmodule

// File: tb/tb_telemetry.sv
// tb/tb_telemetry.sv - scoreboard bench for telemetry: UART decode monitor plus directed timing checks
module tb_telemetry;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] batt, curr, torque;
  logic        send_req;
  logic        TX, busy, pkt_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_pkt    = 0;
  logic [7:0] sb[$];

  telemetry #(.FAST_SIM(1), .BAUD_DIV(BAUD), .PER_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .batt     (batt),
    .curr     (curr),
    .torque   (torque),
    .send_req (send_req),
    .TX       (TX),
    .busy     (busy),
    .pkt_done (pkt_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && pkt_done) n_pkt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push8(input logic [63:0] v);
    for (int i = 7; i >= 0; i--) sb.push_back(v[i*8 +: 8]);
  endtask

  task automatic wait_busy(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (busy) begin at = cyc; break; end
    end
  endtask

  task automatic wait_done(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (pkt_done) begin at = cyc; break; end
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 2000 && cyc < target; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // UART receiver: decodes each frame and compares against the expected-byte queue
  initial begin : monitor
    logic       prev, abort, start_v, stop_v;
    logic [7:0] got;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !TX) begin
        abort = 1'b0;
        got   = 8'h00;
        repeat (BAUD / 2) @(negedge clk);
        if (!rst_n) abort = 1'b1;
        start_v = TX;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          if (!rst_n) abort = 1'b1;
          got[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        if (!rst_n) abort = 1'b1;
        stop_v = TX;
        if (!abort) begin
          check("start_bit", start_v, 1'b0);
          check("stop_bit", stop_v, 1'b1);
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got 0x%0h expected none", got);
          end else begin
            check("packet_byte", got, sb.pop_front());
          end
        end
      end
      prev = TX;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int t0, t1, t2, t3, t4;
    logic bad_tx, bad_busy;
    batt = 12'h5A3; curr = 12'h0C4; torque = 12'h9E1;
    send_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", TX, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_pkt_done", pkt_done, 1'b0);

    // timer expiry with static inputs
    push8(64'hAA55_05A3_00C4_09E1);
    rst_n = 1'b1;
    t0 = cyc;
    wait_busy(400, t1);
    check("tick_trigger_cycle", t1 - t0, 256);
    check("tx_idle_at_trigger", TX, 1'b1);
    @(posedge clk); #1;
    check("first_start_bit", TX, 1'b0);
    wait_done(400, t2);
    check("pkt1_done_latency", t2 - t1, 336);
    @(posedge clk); #1;
    check("pkt1_busy_fall", busy, 1'b0);

    // request, mid-packet input change, dropped request and dropped tick
    @(negedge clk);
    batt = 12'hABC; curr = 12'h123; torque = 12'h7FF;
    push8(64'hAA55_0ABC_0123_07FF);
    send_req = 1'b1;
    @(posedge clk); #1;
    t1 = cyc;
    send_req = 1'b0;
    check("req_busy_rise", busy, 1'b1);
    t2 = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (cyc - t1 == 140) begin
        batt = 12'h000; curr = 12'hFFF; torque = 12'h555;
        push8(64'hAA55_0000_0FFF_0555);
      end
      send_req = (cyc - t1 == 200);
      if (pkt_done) begin t2 = cyc; break; end
    end
    send_req = 1'b0;
    check("req_pkt_done_latency", t2 - t1, 336);
    @(posedge clk); #1;
    check("req_busy_fall", busy, 1'b0);
    wait_busy(400, t3);
    check("next_trigger_after_drops", t3 - t1, 512);
    wait_done(400, t2);
    check("pkt3_done_latency", t2 - t3, 336);

    // send_req coincident with tick
    wait_cyc(t3 + 511);
    batt = 12'h3C0; curr = 12'h801; torque = 12'h07E;
    push8(64'hAA55_03C0_0801_007E);
    send_req = 1'b1;
    @(posedge clk); #1;
    t4 = cyc;
    send_req = 1'b0;
    check("coincident_busy", busy, 1'b1);
    check("coincident_trigger_cycle", t4 - t3, 512);
    wait_done(400, t2);
    check("coincident_pkt_done", t2 - t4, 336);
    @(posedge clk); #1;
    check("coincident_busy_fall", busy, 1'b0);
    wait_busy(400, t1);
    check("tick_after_coincident", t1 - t4, 512);

    // reset during byte 5
    push8(64'hAA55_03C0_0801_007E);
    wait_cyc(t1 + 230);
    check("tx_before_reset", TX, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("reset_tx_async", TX, 1'b1);
    check("reset_busy_async", busy, 1'b0);
    sb.delete();
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    bad_tx = 1'b0; bad_busy = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (TX !== 1'b1) bad_tx = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    check("tx_idle_after_reset", bad_tx, 1'b0);
    check("busy_low_after_reset", bad_busy, 1'b0);
    repeat (20) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("pkt_done_count", n_pkt, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
